// File: rtl/dataint_parity_check_stage.sv
// rtl/dataint_parity_check_stage.sv - registered per-chunk parity check stage with sticky error status
module dataint_parity_check_stage #(
    parameter int CHUNKS = 4,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [WIDTH-1:0]            i_data,
    input  logic [CHUNKS-1:0]           i_parity,
    input  logic                        i_parity_type,
    input  logic                        i_clear,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [WIDTH-1:0]            o_data,
    output logic [CHUNKS-1:0]           o_err_mask,
    output logic                        o_err_sticky,
    output logic [CNT_W-1:0]            o_err_count,
    output logic                        o_first_err_vld,
    output logic [$clog2(CHUNKS)-1:0]   o_first_err_chunk
);

    localparam int C     = WIDTH / CHUNKS;
    localparam int IDX_W = $clog2(CHUNKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHUNKS-1:0] chunk_xor;
    logic [CHUNKS-1:0] err;
    logic [IDX_W-1:0]  first_idx;
    logic              accept;
    logic              emit;

    // The last chunk absorbs the WIDTH % CHUNKS remainder bits.
    for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
        localparam int LO = gi * C;
        localparam int HI = (gi == CHUNKS - 1) ? WIDTH - 1 : (gi + 1) * C - 1;
        assign chunk_xor[gi] = ^i_data[HI:LO];
    end

    assign err = (i_parity_type ? chunk_xor : ~chunk_xor) ^ i_parity;

    always_comb begin
        first_idx = '0;
        for (int i = CHUNKS - 1; i >= 0; i--) begin
            if (err[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;
    assign emit    = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid           <= 1'b0;
            o_data            <= '0;
            o_err_mask        <= '0;
            o_err_sticky      <= 1'b0;
            o_err_count       <= '0;
            o_first_err_vld   <= 1'b0;
            o_first_err_chunk <= '0;
        end else begin
            if (accept) begin
                o_valid    <= 1'b1;
                o_data     <= i_data;
                o_err_mask <= err;
            end else if (emit) begin
                o_valid <= 1'b0;
            end

            if (i_clear) begin
                o_err_sticky      <= 1'b0;
                o_err_count       <= '0;
                o_first_err_vld   <= 1'b0;
                o_first_err_chunk <= '0;
            end

            // An errored beat accepted alongside a clear is recorded on top of the cleared state.
            if (accept && |err) begin
                o_err_sticky <= 1'b1;
                if (i_clear) begin
                    o_err_count <= CNT_W'(1);
                end else if (o_err_count != CNT_MAX) begin
                    o_err_count <= o_err_count + CNT_W'(1);
                end
                if (i_clear || !o_first_err_vld) begin
                    o_first_err_vld   <= 1'b1;
                    o_first_err_chunk <= first_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_dataint_parity_check_stage.sv
// tb/tb_dataint_parity_check_stage.sv - scoreboard bench for dataint_parity_check_stage
module tb_dataint_parity_check_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A (32/4/16) and S (32/4/2) share inputs; B is 10/3/16.
    logic        a_valid, a_type, a_clear, a_rdy_in;
    logic [31:0] a_data;
    logic [3:0]  a_parity;
    logic        a_ready, a_ovalid, a_sticky, a_fvld;
    logic [31:0] a_odata;
    logic [3:0]  a_mask;
    logic [15:0] a_count;
    logic [1:0]  a_fchunk;

    logic        s_ready, s_ovalid, s_sticky, s_fvld;
    logic [31:0] s_odata;
    logic [3:0]  s_mask;
    logic [1:0]  s_count;
    logic [1:0]  s_fchunk;

    logic        b_valid, b_type, b_clear, b_rdy_in;
    logic [9:0]  b_data;
    logic [2:0]  b_parity;
    logic        b_ready, b_ovalid, b_sticky, b_fvld;
    logic [9:0]  b_odata;
    logic [2:0]  b_mask;
    logic [15:0] b_count;
    logic [1:0]  b_fchunk;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    dataint_parity_check_stage #(.CHUNKS(4), .WIDTH(32), .CNT_W(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
        .i_data(a_data), .i_parity(a_parity), .i_parity_type(a_type), .i_clear(a_clear),
        .o_valid(a_ovalid), .i_ready(a_rdy_in), .o_data(a_odata), .o_err_mask(a_mask),
        .o_err_sticky(a_sticky), .o_err_count(a_count), .o_first_err_vld(a_fvld),
        .o_first_err_chunk(a_fchunk)
    );

    dataint_parity_check_stage #(.CHUNKS(4), .WIDTH(32), .CNT_W(2)) u_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(s_ready),
        .i_data(a_data), .i_parity(a_parity), .i_parity_type(a_type), .i_clear(a_clear),
        .o_valid(s_ovalid), .i_ready(a_rdy_in), .o_data(s_odata), .o_err_mask(s_mask),
        .o_err_sticky(s_sticky), .o_err_count(s_count), .o_first_err_vld(s_fvld),
        .o_first_err_chunk(s_fchunk)
    );

    dataint_parity_check_stage #(.CHUNKS(3), .WIDTH(10), .CNT_W(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(b_data), .i_parity(b_parity), .i_parity_type(b_type), .i_clear(b_clear),
        .o_valid(b_ovalid), .i_ready(b_rdy_in), .o_data(b_odata), .o_err_mask(b_mask),
        .o_err_sticky(b_sticky), .o_err_count(b_count), .o_first_err_vld(b_fvld),
        .o_first_err_chunk(b_fchunk)
    );

    function automatic logic [31:0] model_mask(int w, int ch, logic [31:0] d,
                                               logic [31:0] p, logic even);
        logic [31:0] x;
        logic [31:0] m;
        int          c;
        int          idx;
        x = '0;
        m = '0;
        c = w / ch;
        for (int b = 0; b < w; b++) begin
            idx = b / c;
            if (idx > ch - 1) idx = ch - 1;
            x[idx] = x[idx] ^ d[b];
        end
        for (int i = 0; i < ch; i++) begin
            m[i] = ((even ? x[i] : ~x[i]) != p[i]);
        end
        return m;
    endfunction

    // One clock: settle inputs, score emits/accepts, advance past the edge.
    task automatic cyc();
        logic [63:0] e;
        #1;
        if (rst_n) begin
            if (a_ovalid && a_rdy_in) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_a_unexpected got data=%h mask=%b", a_odata, a_mask);
                end else begin
                    e = q0.pop_front();
                    if ({a_odata, 28'b0, a_mask} !== e) begin
                        bad++;
                        $display("FAIL sb_a got data=%h mask=%b want data=%h mask=%b",
                                 a_odata, a_mask, e[63:32], e[3:0]);
                    end
                end
            end
            if (a_valid && a_ready)
                q0.push_back({a_data, model_mask(32, 4, a_data, {28'b0, a_parity}, a_type)});
            if (b_ovalid && b_rdy_in) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_b_unexpected got data=%h mask=%b", b_odata, b_mask);
                end else begin
                    e = q1.pop_front();
                    if ({22'b0, b_odata, 29'b0, b_mask} !== e) begin
                        bad++;
                        $display("FAIL sb_b got data=%h mask=%b want data=%h mask=%b",
                                 b_odata, b_mask, e[41:32], e[2:0]);
                    end
                end
            end
            if (b_valid && b_ready)
                q1.push_back({22'b0, b_data, model_mask(10, 3, {22'b0, b_data}, {29'b0, b_parity}, b_type)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 0; a_data = 0; a_parity = 0; a_type = 1; a_clear = 0; a_rdy_in = 1;
        b_valid = 0; b_data = 0; b_parity = 0; b_type = 0; b_clear = 0; b_rdy_in = 1;
        cyc();
        cyc();
        chk("rst_a_ovalid", 32'(a_ovalid), 0);
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_a_data", a_odata, 0);
        chk("rst_a_status", {a_sticky, a_fvld, a_fchunk, 12'b0, a_count}, 0);
        chk("rst_b_ovalid", 32'(b_ovalid), 0);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_clean();
        a_valid = 1; a_data = 32'h0000_0001; a_parity = 4'b0001; a_rdy_in = 1;
        cyc();
        chk("clean_ovalid", 32'(a_ovalid), 1);
        chk("clean_data", a_odata, 32'h1);
        chk("clean_mask", 32'(a_mask), 0);
        chk("clean_sticky", 32'(a_sticky), 0);
        chk("clean_count", 32'(a_count), 0);
    endtask

    task automatic test_single_err();
        a_parity = 4'b0000;
        cyc();
        chk("err1_mask", 32'(a_mask), 32'b0001);
        chk("err1_sticky", 32'(a_sticky), 1);
        chk("err1_count", 32'(a_count), 1);
        chk("err1_first", {a_fvld, a_fchunk}, 32'b100);
        a_data = 32'h0100_0000;
        cyc();
        chk("err2_mask", 32'(a_mask), 32'b1000);
        chk("err2_count", 32'(a_count), 2);
        chk("err2_first", {a_fvld, a_fchunk}, 32'b100);
        a_valid = 0;
        cyc();
        chk("err_drain_ovalid", 32'(a_ovalid), 0);
    endtask

    task automatic test_odd_remainder();
        b_valid = 1; b_type = 0; b_data = 10'h000; b_parity = 3'b111; b_rdy_in = 1;
        cyc();
        chk("odd_clean_mask", 32'(b_mask), 0);
        b_data = 10'h200;
        cyc();
        chk("odd_rem_mask", 32'(b_mask), 32'b100);
        chk("odd_rem_first", {b_fvld, b_fchunk}, 32'b110);
        b_valid = 0;
        cyc();
    endtask

    task automatic test_backpressure();
        a_clear = 1;
        cyc();
        a_clear = 0;
        chk("clear_count", 32'(a_count), 0);
        chk("clear_status", {a_sticky, a_fvld, a_fchunk}, 0);
        a_valid = 1; a_data = 32'h1; a_parity = 4'b0000; a_rdy_in = 0;
        cyc();
        a_data = 32'h2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_ready", 32'(a_ready), 0);
            chk("bp_data", a_odata, 32'h1);
            chk("bp_mask", 32'(a_mask), 32'b0001);
            chk("bp_count", 32'(a_count), 1);
        end
        a_rdy_in = 1;
        cyc();
        chk("bp_reload_ovalid", 32'(a_ovalid), 1);
        chk("bp_reload_data", a_odata, 32'h2);
        chk("bp_reload_count", 32'(a_count), 2);
        a_valid = 0;
        cyc();
    endtask

    task automatic test_saturation();
        a_clear = 1;
        cyc();
        a_clear = 0;
        a_valid = 1; a_data = 32'h1; a_parity = 4'b0000; a_rdy_in = 1;
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_s_count", 32'(s_count), 3);
        chk("sat_a_count", 32'(a_count), 5);
        a_clear = 1; a_data = 32'h0; a_parity = 4'b0110;
        cyc();
        a_clear = 0;
        chk("coll_mask", 32'(s_mask), 32'b0110);
        chk("coll_s_count", 32'(s_count), 1);
        chk("coll_a_count", 32'(a_count), 1);
        chk("coll_sticky", 32'(s_sticky), 1);
        chk("coll_first", {s_fvld, s_fchunk}, 32'b101);
        a_valid = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        a_valid = 1; a_data = 32'h1; a_parity = 4'b0000; a_rdy_in = 0;
        cyc();
        chk("mid_ovalid_pre", 32'(a_ovalid), 1);
        rst_n = 0;
        cyc();
        chk("mid_ovalid", 32'(a_ovalid), 0);
        chk("mid_data", {a_odata[27:0], a_mask}, 0);
        chk("mid_status", {a_sticky, a_fvld, a_fchunk, 12'b0, a_count}, 0);
        q0.delete();
        q1.delete();
        rst_n = 1;
        a_valid = 0; a_rdy_in = 1;
        cyc();
        chk("mid_ready", 32'(a_ready), 1);
        a_valid = 1; a_data = 32'h0100_0000; a_parity = 4'b1000;
        cyc();
        chk("mid_lat_ovalid", 32'(a_ovalid), 1);
        chk("mid_lat_data", a_odata, 32'h0100_0000);
        a_valid = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            a_valid = 1'($urandom_range(0, 3) != 0);
            a_data = $urandom;
            a_parity = 4'($urandom_range(0, 15));
            a_rdy_in = 1'($urandom_range(0, 3) != 0);
            b_valid = 1'($urandom_range(0, 3) != 0);
            b_data = 10'($urandom);
            b_parity = 3'($urandom_range(0, 7));
            b_rdy_in = 1'($urandom_range(0, 2) != 0);
            cyc();
        end
        a_valid = 0; a_rdy_in = 1;
        b_valid = 0; b_rdy_in = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("b2b_q0_empty", 32'(q0.size()), 0);
        chk("b2b_q1_empty", 32'(q1.size()), 0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_odd_remainder();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
